// File: rtl/stream_unpacker.sv
// rtl/stream_unpacker.sv - packed RGB888 AXI4-Stream sink unpacking 3 beats into 4 pixels with framing checks
module stream_unpacker #(
  parameter int X_SIZE    = 640,
  parameter int Y_SIZE    = 480,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 aclk,
  input  logic                 reset,
  input  logic [31:0]          in_stream_tdata,
  input  logic [3:0]           in_stream_tkeep,
  input  logic                 in_stream_tlast,
  input  logic                 in_stream_tuser,
  input  logic                 in_stream_tvalid,
  output logic                 in_stream_tready,
  output logic [7:0]           pix_r,
  output logic [7:0]           pix_g,
  output logic [7:0]           pix_b,
  output logic [9:0]           pix_x,
  output logic [8:0]           pix_y,
  output logic                 pix_sof,
  output logic                 pix_eol,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
  localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

  // Leftover bytes from the previous beat; byte 0 (oldest) sits in bits [7:0]
  logic [1:0]  lcnt;
  logic [23:0] lbuf;
  // tlast of the beat that filled the buffer; tags the drain pixel as eol
  logic        last_flag;
  // Coordinates the next non-sof pixel will take
  logic [9:0]  next_x;
  logic [8:0]  next_y;

  logic        load_ok;
  logic        accept;
  logic        drain;
  logic        load;
  logic        user_err;
  logic        last_err;
  logic        keep_err;
  logic        coord_err;
  logic        any_err;
  logic [1:0]  eff_l;
  logic [23:0] buf_mask;
  logic [55:0] cat;
  logic [23:0] ld_rgb;
  logic        ld_sof;
  logic        ld_eol;
  logic [9:0]  ld_x;
  logic [8:0]  ld_y;

  assign load_ok          = !pix_valid || pix_ready;
  assign in_stream_tready = !reset && (lcnt != 2'd3) && load_ok;
  assign accept           = in_stream_tvalid && in_stream_tready;
  assign drain            = (lcnt == 2'd3) && load_ok;
  assign load             = accept || drain;

  // Byte concatenation of leftovers and the incoming beat, pixel selection and error detection
  always_comb begin
    user_err = in_stream_tuser && (lcnt != 2'd0);
    // a start-of-frame beat always restarts the group, dropping any leftovers
    eff_l    = in_stream_tuser ? 2'd0 : lcnt;
    last_err = in_stream_tlast && (eff_l != 2'd2);
    keep_err = in_stream_tkeep != 4'hF;
    case (eff_l)
      2'd0:    buf_mask = 24'h000000;
      2'd1:    buf_mask = 24'h0000FF;
      2'd2:    buf_mask = 24'h00FFFF;
      default: buf_mask = 24'hFFFFFF;
    endcase
    cat       = ({24'd0, in_stream_tdata} << {eff_l, 3'b000}) | {32'd0, lbuf & buf_mask};
    ld_rgb    = drain ? lbuf : cat[23:0];
    ld_sof    = accept && in_stream_tuser;
    ld_eol    = drain ? last_flag : (accept && last_err);
    ld_x      = ld_sof ? 10'd0 : next_x;
    ld_y      = ld_sof ? 9'd0 : next_y;
    // line length is checked against what was received; coordinates still follow the flags
    coord_err = load && (ld_eol ? (ld_x != X_LAST) : (ld_x == X_LAST));
    any_err   = (accept && (user_err || last_err || keep_err)) || coord_err;
  end

  // Leftover-count state machine, pixel register, coordinate tracking and error counter
  always_ff @(posedge aclk) begin
    if (reset) begin
      lcnt      <= 2'd0;
      lbuf      <= 24'd0;
      last_flag <= 1'b0;
      next_x    <= 10'd0;
      next_y    <= 9'd0;
      pix_valid <= 1'b0;
      pix_r     <= 8'd0;
      pix_g     <= 8'd0;
      pix_b     <= 8'd0;
      pix_x     <= 10'd0;
      pix_y     <= 9'd0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      if (accept) begin
        lcnt      <= last_err ? 2'd0 : eff_l + 2'd1;
        lbuf      <= cat[47:24];
        last_flag <= in_stream_tlast && !last_err;
      end else if (drain) begin
        lcnt <= 2'd0;
      end

      if (load) begin
        pix_valid <= 1'b1;
        {pix_b, pix_g, pix_r} <= ld_rgb;
        pix_x     <= ld_x;
        pix_y     <= ld_y;
        pix_sof   <= ld_sof;
        pix_eol   <= ld_eol;
        if (ld_eol) begin
          next_x <= 10'd0;
          next_y <= (ld_y == Y_LAST) ? 9'd0 : ld_y + 9'd1;
        end else begin
          next_x <= ld_x + 10'd1;
          next_y <= ld_y;
        end
      end else if (pix_ready) begin
        pix_valid <= 1'b0;
      end

      err_pulse <= any_err;
      if (any_err && (err_count != '1)) begin
        err_count <= err_count + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_unpacker.sv
// tb/tb_stream_unpacker.sv - self-checking bench for stream_unpacker
module tb_stream_unpacker;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_stream_tdata = 32'd0;
  logic [3:0]  in_stream_tkeep = 4'hF;
  logic        in_stream_tlast = 1'b0;
  logic        in_stream_tuser = 1'b0;
  logic        in_stream_tvalid = 1'b0;
  logic        in_stream_tready;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_sof, pix_eol, pix_valid;
  logic        pix_ready;
  logic        err_pulse;
  logic [15:0] err_count;

  logic man_ready = 1'b0;
  logic rand_ready = 1'b0;
  logic rnd_bit = 1'b0;
  assign pix_ready = rand_ready ? rnd_bit : man_ready;

  stream_unpacker #(.X_SIZE(640), .Y_SIZE(480), .ERR_CNT_W(16)) dut (
    .aclk(aclk), .reset(reset),
    .in_stream_tdata(in_stream_tdata), .in_stream_tkeep(in_stream_tkeep),
    .in_stream_tlast(in_stream_tlast), .in_stream_tuser(in_stream_tuser),
    .in_stream_tvalid(in_stream_tvalid), .in_stream_tready(in_stream_tready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_x(pix_x), .pix_y(pix_y),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 aclk = ~aclk;

  // Monitor: captured pixels, beat acceptance cycles and error pulses
  logic [44:0] cap_q[$];
  int          acc_cyc_q[$];
  int          cyc = 0;
  int          err_pulses = 0;

  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (pix_valid && pix_ready) cap_q.push_back({pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol});
    if (in_stream_tvalid && in_stream_tready) acc_cyc_q.push_back(cyc);
    if (err_pulse) err_pulses <= err_pulses + 1;
  end

  initial forever begin
    @(negedge aclk);
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [44:0] mkpix(input logic [23:0] rgb, input int x, input int y,
                                        input logic s, input logic e);
    return {rgb, 10'(x), 9'(y), s, e};
  endfunction

  function automatic logic [31:0] pat(input int b);
    return {8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)};
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic u, input logic l, input logic [3:0] k);
    int n;
    @(negedge aclk);
    in_stream_tdata  = d;
    in_stream_tuser  = u;
    in_stream_tlast  = l;
    in_stream_tkeep  = k;
    in_stream_tvalid = 1'b1;
    n = 0;
    #1;
    while (!in_stream_tready && n < 200) begin
      @(negedge aclk);
      #1;
      n++;
    end
    if (!in_stream_tready) begin
      chk("send_timeout", 64'd0, 64'd1);
      in_stream_tvalid = 1'b0;
    end else begin
      @(posedge aclk);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      in_stream_tvalid = 1'b0;
      in_stream_tuser  = 1'b0;
      in_stream_tlast  = 1'b0;
      in_stream_tkeep  = 4'hF;
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    reset = 1'b1;
    in_stream_tvalid = 1'b0;
    repeat (2) @(negedge aclk);
    reset = 1'b0;
  endtask

  task automatic wait_pix(input int target, input int budget);
    int n;
    n = 0;
    while (cap_q.size() < target && n < budget) begin
      @(negedge aclk);
      n++;
    end
    repeat (4) @(negedge aclk);
  endtask

  task automatic cmp_run(input string name, input int base, input logic [44:0] exp_q[$]);
    chk({name, "_count"}, 64'(cap_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < cap_q.size()) chk($sformatf("%s_pix%0d", name, i), 64'(cap_q[base+i]), 64'(exp_q[i]));
      else chk($sformatf("%s_pix%0d", name, i), {64{1'bx}}, 64'(exp_q[i]));
    end
  endtask

  typedef struct {
    logic [31:0]       d0, d1, d2;
    logic              usr, lst;
    logic [3:0]        k1;
    logic [3:0][23:0]  px;
    int                err;
  } grp_t;

  grp_t        tbl[4];
  logic [44:0] exp_q[$];
  logic [7:0]  rb[0:3839];
  int          base, e0, a0, o;
  logic        ok;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 1'b1, 1'b0, 4'hF,
               {24'hAABBCC, 24'h778899, 24'h445566, 24'h112233}, 0};
    tbl[1] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 1'b1, 1'b0, 4'hF,
               {24'h090A0B, 24'h060708, 24'h030405, 24'h000102}, 0};
    tbl[2] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 1'b1, 1'b0, 4'h7,
               {24'hCDAB89, 24'h2301EF, 24'hDE6745, 24'hEFBEAD}, 1};
    tbl[3] = '{32'hFFEEDDCC, 32'hBBAA9988, 32'h77665544, 1'b1, 1'b1, 4'hF,
               {24'h556677, 24'hAABB44, 24'hFF8899, 24'hCCDDEE}, 1};

    // Reset held two cycles with a valid beat offered
    man_ready = 1'b1;
    repeat (2) @(negedge aclk);
    in_stream_tvalid = 1'b1;
    in_stream_tdata  = 32'hA5A5A5A5;
    in_stream_tuser  = 1'b1;
    a0 = acc_cyc_q.size();
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      #1;
      chk("rst_tready", in_stream_tready, 0);
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_err_count", err_count, 0);
    end
    @(negedge aclk);
    reset = 1'b0;
    in_stream_tvalid = 1'b0;
    in_stream_tuser  = 1'b0;
    #1;
    chk("rst_no_accept", 64'(acc_cyc_q.size() - a0), 0);
    chk("rst_outputs", {pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol, err_pulse}, 0);

    // Table of single groups
    for (int t = 0; t < 4; t++) begin
      base = cap_q.size();
      e0 = err_pulses;
      send_beat(tbl[t].d0, tbl[t].usr, 1'b0, 4'hF);
      send_beat(tbl[t].d1, 1'b0, 1'b0, tbl[t].k1);
      send_beat(tbl[t].d2, 1'b0, tbl[t].lst, 4'hF);
      #1;
      chk($sformatf("tbl%0d_tready_after_b2", t), in_stream_tready, 0);
      idle(6);
      exp_q.delete();
      for (int i = 0; i < 4; i++)
        exp_q.push_back(mkpix(tbl[t].px[i], i, 0, i == 0, (i == 3) && tbl[t].lst));
      cmp_run($sformatf("tbl%0d", t), base, exp_q);
      chk($sformatf("tbl%0d_err", t), 64'(err_pulses - e0), 64'(tbl[t].err));
    end
    chk("tbl_err_count", err_count, 2);

    // Full line at full rate, then the first group of the next line
    do_reset();
    man_ready = 1'b1;
    base = cap_q.size();
    a0 = acc_cyc_q.size();
    e0 = err_pulses;
    for (int b = 0; b < 483; b++) send_beat(pat(b), b == 0, b == 479, 4'hF);
    idle(1);
    wait_pix(base + 644, 2000);
    exp_q.delete();
    for (int n = 0; n < 644; n++)
      exp_q.push_back(mkpix({8'(3*n), 8'(3*n+1), 8'(3*n+2)}, n % 640, n / 640, n == 0, n == 639));
    cmp_run("line", base, exp_q);
    if (acc_cyc_q.size() >= a0 + 480) chk("line_rate", 64'(acc_cyc_q[a0+479] - acc_cyc_q[a0]), 638);
    else chk("line_rate", {64{1'bx}}, 638);
    chk("line_err", 64'(err_pulses - e0), 0);
    chk("line_err_count", err_count, 0);

    // Backpressure mid-group
    do_reset();
    man_ready = 1'b1;
    base = cap_q.size();
    send_beat(pat(0), 1'b1, 1'b0, 4'hF);
    @(negedge aclk);
    man_ready = 1'b0;
    in_stream_tdata = pat(1);
    in_stream_tuser = 1'b0;
    in_stream_tvalid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (in_stream_tready !== 1'b0 || pix_valid !== 1'b1 || {pix_r, pix_g, pix_b} !== 24'h000102 ||
          pix_x !== 10'd0 || pix_sof !== 1'b1) ok = 1'b0;
      @(negedge aclk);
    end
    chk("bp_frozen", ok, 1);
    in_stream_tvalid = 1'b0;
    man_ready = 1'b1;
    send_beat(pat(1), 1'b0, 1'b0, 4'hF);
    send_beat(pat(2), 1'b0, 1'b0, 4'hF);
    idle(1);
    wait_pix(base + 4, 50);
    exp_q.delete();
    for (int n = 0; n < 4; n++) exp_q.push_back(mkpix({8'(3*n), 8'(3*n+1), 8'(3*n+2)}, n, 0, n == 0, 1'b0));
    cmp_run("bp", base, exp_q);

    // Bad tlast on the second beat of a group
    do_reset();
    man_ready = 1'b1;
    base = cap_q.size();
    e0 = err_pulses;
    send_beat(pat(0), 1'b1, 1'b0, 4'hF);
    send_beat(pat(1), 1'b0, 1'b1, 4'hF);
    send_beat(pat(2), 1'b0, 1'b0, 4'hF);
    send_beat(pat(3), 1'b0, 1'b0, 4'hF);
    send_beat(pat(4), 1'b0, 1'b0, 4'hF);
    idle(1);
    wait_pix(base + 6, 50);
    exp_q.delete();
    exp_q.push_back(mkpix(24'h000102, 0, 0, 1'b1, 1'b0));
    exp_q.push_back(mkpix(24'h030405, 1, 0, 1'b0, 1'b1));
    exp_q.push_back(mkpix(24'h08090A, 0, 1, 1'b0, 1'b0));
    exp_q.push_back(mkpix(24'h0B0C0D, 1, 1, 1'b0, 1'b0));
    exp_q.push_back(mkpix(24'h0E0F10, 2, 1, 1'b0, 1'b0));
    exp_q.push_back(mkpix(24'h111213, 3, 1, 1'b0, 1'b0));
    cmp_run("badlast", base, exp_q);
    chk("badlast_pulses", 64'(err_pulses - e0), 1);
    chk("badlast_err_count", err_count, 1);

    // tuser on the second beat of a group, then normal decode
    do_reset();
    man_ready = 1'b1;
    base = cap_q.size();
    e0 = err_pulses;
    send_beat(pat(0), 1'b1, 1'b0, 4'hF);
    send_beat(pat(1), 1'b1, 1'b0, 4'hF);
    for (int b = 2; b < 7; b++) send_beat(pat(b), 1'b0, 1'b0, 4'hF);
    idle(1);
    wait_pix(base + 9, 50);
    exp_q.delete();
    exp_q.push_back(mkpix(24'h000102, 0, 0, 1'b1, 1'b0));
    exp_q.push_back(mkpix(24'h040506, 0, 0, 1'b1, 1'b0));
    exp_q.push_back(mkpix(24'h070809, 1, 0, 1'b0, 1'b0));
    exp_q.push_back(mkpix(24'h0A0B0C, 2, 0, 1'b0, 1'b0));
    exp_q.push_back(mkpix(24'h0D0E0F, 3, 0, 1'b0, 1'b0));
    exp_q.push_back(mkpix(24'h101112, 4, 0, 1'b0, 1'b0));
    exp_q.push_back(mkpix(24'h131415, 5, 0, 1'b0, 1'b0));
    exp_q.push_back(mkpix(24'h161718, 6, 0, 1'b0, 1'b0));
    exp_q.push_back(mkpix(24'h191A1B, 7, 0, 1'b0, 1'b0));
    cmp_run("lateuser", base, exp_q);
    chk("lateuser_err_count", err_count, 1);

    // Randomized two-line frame with random gaps and random consumer stalls
    do_reset();
    rand_ready = 1'b1;
    base = cap_q.size();
    e0 = err_pulses;
    for (int i = 0; i < 3840; i++) rb[i] = 8'($urandom);
    for (int ln = 0; ln < 2; ln++) begin
      for (int b = 0; b < 480; b++) begin
        o = ln * 1920 + 4 * b;
        if ($urandom_range(0, 4) == 0) idle(1);
        send_beat({rb[o+3], rb[o+2], rb[o+1], rb[o]}, (ln == 0) && (b == 0), b == 479, 4'hF);
      end
    end
    idle(1);
    wait_pix(base + 1280, 5000);
    man_ready = 1'b1;
    rand_ready = 1'b0;
    exp_q.delete();
    for (int ln = 0; ln < 2; ln++) begin
      for (int n = 0; n < 640; n++) begin
        o = ln * 1920 + 3 * n;
        exp_q.push_back(mkpix({rb[o], rb[o+1], rb[o+2]}, n, ln, (ln == 0) && (n == 0), n == 639));
      end
    end
    cmp_run("rand", base, exp_q);
    chk("rand_err", 64'(err_pulses - e0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
